apu_front_regs: RTL and testbench

- APU front end: decodes CPU accesses to the sound range, holds the NR52 master-enable/status register, the NR50/NR51 mixer registers and the channel-1 register file (NR10–NR14).
- Drives read data back to the CPU bus.
- Emits channel-1 control fields and one-cycle restart/length-load pulses to the sweep and channel-1 datapaths.

---
 rtl/apu_front_regs.sv | 147 ++++++++++++++
 tb/tb_apu_front_regs.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apu_front_regs.sv
// APU front end: sound-range address decode, NR52 master enable, NR50/NR51 mixer
// and the channel-1 register file, with CPU readback and channel-1 control pulses.
module apu_front_regs (
  input  logic        clk,
  input  logic        nreset,
  input  logic [15:0] a,
  input  logic [7:0]  d_in,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  output logic [7:0]  d_out,
  output logic        d_oe,
  output logic [31:0] apu_sel,
  output logic        ff3x,
  output logic        apu_en,
  output logic        apu_reset,
  input  logic [3:0]  ch_active,
  output logic [2:0]  sweep_time,
  output logic        sweep_neg,
  output logic [2:0]  sweep_shift,
  output logic [1:0]  duty,
  output logic [5:0]  length_data,
  output logic        length_ld,
  output logic [3:0]  env_init,
  output logic        env_up,
  output logic [2:0]  env_period,
  output logic [10:0] freq,
  output logic        length_en,
  output logic        ch1_restart,
  input  logic        sweep_freq_ld,
  input  logic [10:0] sweep_freq,
  output logic [7:0]  nr50,
  output logic [7:0]  nr51
);

  logic [6:0]  nr10_q;
  logic [7:0]  nr11_q;
  logic [7:0]  nr12_q;
  logic [10:0] freq_q;
  logic [10:0] freq_d;
  logic        length_en_q;
  logic [7:0]  nr50_q;
  logic [7:0]  nr51_q;
  logic        apu_en_q;
  logic        length_ld_q;
  logic        ch1_restart_q;
  logic        wr_ok;

  always_comb begin
    apu_sel = '0;
    for (int i = 0; i < 32; i++) begin
      apu_sel[i] = (a == 16'(32'hFF10 + i));
    end
  end

  assign ff3x  = (a[15:4] == 12'hFF3);
  // Register-file writes are only accepted while the APU is powered.
  assign wr_ok = cpu_wr & apu_en_q;

  // CPU bytes win over the sweep unit for the bits they write.
  always_comb begin
    freq_d = sweep_freq_ld ? sweep_freq : freq_q;
    if (wr_ok && apu_sel[3]) freq_d[7:0]  = d_in;
    if (wr_ok && apu_sel[4]) freq_d[10:8] = d_in[2:0];
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      nr10_q        <= '0;
      nr11_q        <= '0;
      nr12_q        <= '0;
      freq_q        <= '0;
      length_en_q   <= 1'b0;
      nr50_q        <= '0;
      nr51_q        <= '0;
      apu_en_q      <= 1'b0;
      length_ld_q   <= 1'b0;
      ch1_restart_q <= 1'b0;
    end else begin
      length_ld_q   <= 1'b0;
      ch1_restart_q <= 1'b0;
      if (cpu_wr && apu_sel[22]) apu_en_q <= d_in[7];
      if (!apu_en_q) begin
        nr10_q      <= '0;
        nr11_q      <= '0;
        nr12_q      <= '0;
        freq_q      <= '0;
        length_en_q <= 1'b0;
        nr50_q      <= '0;
        nr51_q      <= '0;
      end else begin
        freq_q <= freq_d;
        if (wr_ok && apu_sel[0]) nr10_q <= d_in[6:0];
        if (wr_ok && apu_sel[1]) begin
          nr11_q      <= d_in;
          length_ld_q <= 1'b1;
        end
        if (wr_ok && apu_sel[2]) nr12_q <= d_in;
        if (wr_ok && apu_sel[4]) begin
          length_en_q   <= d_in[6];
          ch1_restart_q <= d_in[7];
        end
        if (wr_ok && apu_sel[20]) nr50_q <= d_in;
        if (wr_ok && apu_sel[21]) nr51_q <= d_in;
      end
    end
  end

  always_comb begin
    d_oe  = 1'b0;
    d_out = 8'hFF;
    if (cpu_rd) begin
      d_oe = 1'b1;
      unique case (a)
        16'hFF10: d_out = {1'b1, nr10_q};
        16'hFF11: d_out = {nr11_q[7:6], 6'h3F};
        16'hFF12: d_out = nr12_q;
        16'hFF13: d_out = 8'hFF;
        16'hFF14: d_out = {1'b1, length_en_q, 6'h3F};
        16'hFF24: d_out = nr50_q;
        16'hFF25: d_out = nr51_q;
        16'hFF26: d_out = {apu_en_q, 3'b111, ch_active & {4{apu_en_q}}};
        default: begin
          d_oe  = 1'b0;
          d_out = 8'hFF;
        end
      endcase
    end
  end

  assign apu_en      = apu_en_q;
  assign apu_reset   = ~apu_en_q;
  assign sweep_time  = nr10_q[6:4];
  assign sweep_neg   = nr10_q[3];
  assign sweep_shift = nr10_q[2:0];
  assign duty        = nr11_q[7:6];
  assign length_data = nr11_q[5:0];
  assign length_ld   = length_ld_q;
  assign env_init    = nr12_q[7:4];
  assign env_up      = nr12_q[3];
  assign env_period  = nr12_q[2:0];
  assign freq        = freq_q;
  assign length_en   = length_en_q;
  assign ch1_restart = ch1_restart_q;
  assign nr50        = nr50_q;
  assign nr51        = nr51_q;

endmodule

// File: tb/tb_apu_front_regs.sv
// Directed bench for apu_front_regs with hand-computed expectations.
module tb_apu_front_regs;

  logic        clk;
  logic        nreset;
  logic [15:0] a;
  logic [7:0]  d_in;
  logic        cpu_wr;
  logic        cpu_rd;
  logic [7:0]  d_out;
  logic        d_oe;
  logic [31:0] apu_sel;
  logic        ff3x;
  logic        apu_en;
  logic        apu_reset;
  logic [3:0]  ch_active;
  logic [2:0]  sweep_time;
  logic        sweep_neg;
  logic [2:0]  sweep_shift;
  logic [1:0]  duty;
  logic [5:0]  length_data;
  logic        length_ld;
  logic [3:0]  env_init;
  logic        env_up;
  logic [2:0]  env_period;
  logic [10:0] freq;
  logic        length_en;
  logic        ch1_restart;
  logic        sweep_freq_ld;
  logic [10:0] sweep_freq;
  logic [7:0]  nr50;
  logic [7:0]  nr51;

  int checks = 0;
  int errors = 0;

  apu_front_regs dut (
    .clk(clk), .nreset(nreset), .a(a), .d_in(d_in), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
    .d_out(d_out), .d_oe(d_oe), .apu_sel(apu_sel), .ff3x(ff3x), .apu_en(apu_en),
    .apu_reset(apu_reset), .ch_active(ch_active), .sweep_time(sweep_time),
    .sweep_neg(sweep_neg), .sweep_shift(sweep_shift), .duty(duty),
    .length_data(length_data), .length_ld(length_ld), .env_init(env_init),
    .env_up(env_up), .env_period(env_period), .freq(freq), .length_en(length_en),
    .ch1_restart(ch1_restart), .sweep_freq_ld(sweep_freq_ld), .sweep_freq(sweep_freq),
    .nr50(nr50), .nr51(nr51)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one write across a single rising edge; returns #1 after that edge.
  task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data);
    a      = addr;
    d_in   = data;
    cpu_wr = 1'b1;
    @(posedge clk);
    #1;
    cpu_wr = 1'b0;
  endtask

  task automatic cpu_read(input string tag, input logic [15:0] addr, input logic [7:0] exp);
    a      = addr;
    cpu_rd = 1'b1;
    #1;
    check(tag, d_out, exp);
    check({tag, "_oe"}, d_oe, 1'b1);
    cpu_rd = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nreset        = 1'b0;
    a             = 16'h0000;
    d_in          = 8'h00;
    cpu_wr        = 1'b0;
    cpu_rd        = 1'b0;
    ch_active     = 4'b0000;
    sweep_freq_ld = 1'b0;
    sweep_freq    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nreset = 1'b1;
    #1;

    // Reset readback
    cpu_read("rst_ff10", 16'hFF10, 8'h80);
    cpu_read("rst_ff11", 16'hFF11, 8'h3F);
    cpu_read("rst_ff12", 16'hFF12, 8'h00);
    cpu_read("rst_ff13", 16'hFF13, 8'hFF);
    cpu_read("rst_ff14", 16'hFF14, 8'hBF);
    cpu_read("rst_ff24", 16'hFF24, 8'h00);
    cpu_read("rst_ff25", 16'hFF25, 8'h00);
    cpu_read("rst_ff26", 16'hFF26, 8'h70);
    check("rst_apu_reset", apu_reset, 1'b1);
    check("rst_apu_en", apu_en, 1'b0);

    // Decode and idle bus
    a = 16'hFF13;
    #1;
    check("sel_ff13", apu_sel, 32'h0000_0008);
    check("noread_oe", d_oe, 1'b0);
    check("noread_dout", d_out, 8'hFF);
    a = 16'hFF2F;
    #1;
    check("sel_ff2f", apu_sel, 32'h8000_0000);
    check("ff3x_lo", ff3x, 1'b0);
    a = 16'hFF3A;
    #1;
    check("sel_ff3a", apu_sel, 32'h0);
    check("ff3x_hi", ff3x, 1'b1);
    a      = 16'hFF15;
    cpu_rd = 1'b1;
    #1;
    check("unmapped_oe", d_oe, 1'b0);
    check("unmapped_dout", d_out, 8'hFF);
    cpu_rd = 1'b0;

    // Writes ignored while disabled
    cpu_write(16'hFF12, 8'hF3);
    cpu_read("dis_ff12", 16'hFF12, 8'h00);

    cpu_write(16'hFF26, 8'h80);
    check("en_apu_en", apu_en, 1'b1);
    check("en_apu_reset", apu_reset, 1'b0);
    cpu_write(16'hFF12, 8'hF3);
    cpu_read("en_ff12", 16'hFF12, 8'hF3);
    check("env_init", env_init, 4'hF);
    check("env_up", env_up, 1'b0);
    check("env_period", env_period, 3'd3);

    // Frequency and restart pulse
    cpu_write(16'hFF13, 8'h34);
    check("restart_after_ff13", ch1_restart, 1'b0);
    cpu_write(16'hFF14, 8'hC5);
    check("restart_hi", ch1_restart, 1'b1);
    check("freq_534", freq, 11'h534);
    check("length_en", length_en, 1'b1);
    tick();
    check("restart_lo", ch1_restart, 1'b0);
    cpu_read("ff14_read", 16'hFF14, 8'hFF);
    cpu_write(16'hFF14, 8'h05);
    check("restart_bit7_clr", ch1_restart, 1'b0);
    check("length_en_clr", length_en, 1'b0);
    cpu_read("ff14_read2", 16'hFF14, 8'hBF);

    // Length load pulse
    cpu_write(16'hFF11, 8'h9A);
    check("length_ld_hi", length_ld, 1'b1);
    check("duty", duty, 2'd2);
    check("length_data", length_data, 6'h1A);
    tick();
    check("length_ld_lo", length_ld, 1'b0);
    cpu_read("ff11_read", 16'hFF11, 8'hBF);

    // Sustained write pulses every edge
    a      = 16'hFF11;
    d_in   = 8'h41;
    cpu_wr = 1'b1;
    tick();
    check("sustain_ld1", length_ld, 1'b1);
    tick();
    check("sustain_ld2", length_ld, 1'b1);
    cpu_wr = 1'b0;
    tick();
    check("sustain_ld_end", length_ld, 1'b0);

    // Sweep register and mixer
    cpu_write(16'hFF10, 8'hA5);
    check("sweep_time", sweep_time, 3'd2);
    check("sweep_neg", sweep_neg, 1'b0);
    check("sweep_shift", sweep_shift, 3'd5);
    cpu_read("ff10_read", 16'hFF10, 8'hA5);
    cpu_write(16'hFF24, 8'h77);
    cpu_write(16'hFF25, 8'hF3);
    check("nr50", nr50, 8'h77);
    check("nr51", nr51, 8'hF3);
    cpu_read("ff24_read", 16'hFF24, 8'h77);
    cpu_read("ff25_read", 16'hFF25, 8'hF3);

    ch_active = 4'b0101;
    cpu_read("ff26_active", 16'hFF26, 8'hF5);

    // Sweep loads, alone and merged with CPU writes
    sweep_freq_ld = 1'b1;
    sweep_freq    = 11'h7FF;
    tick();
    sweep_freq_ld = 1'b0;
    check("sweep_7ff", freq, 11'h7FF);
    sweep_freq_ld = 1'b1;
    cpu_write(16'hFF13, 8'h00);
    sweep_freq_ld = 1'b0;
    check("sweep_ff13", freq, 11'h700);
    sweep_freq_ld = 1'b1;
    sweep_freq    = 11'h0AB;
    cpu_write(16'hFF14, 8'h02);
    sweep_freq_ld = 1'b0;
    check("sweep_ff14", freq, 11'h2AB);

    // Disable clears everything on the following edge
    cpu_write(16'hFF26, 8'h00);
    check("dis_apu_en", apu_en, 1'b0);
    check("dis_apu_reset", apu_reset, 1'b1);
    tick();
    cpu_read("dis_ff26", 16'hFF26, 8'h70);
    check("dis_nr10", {sweep_time, sweep_neg, sweep_shift}, 7'h00);
    check("dis_nr11", {duty, length_data}, 8'h00);
    check("dis_nr12", {env_init, env_up, env_period}, 8'h00);
    check("dis_freq", freq, 11'h000);
    check("dis_len_en", length_en, 1'b0);
    check("dis_nr50", nr50, 8'h00);
    check("dis_nr51", nr51, 8'h00);
    cpu_write(16'hFF11, 8'hFF);
    check("dis_ld_blocked", length_ld, 1'b0);

    // Re-enable does not restore old contents
    cpu_write(16'hFF26, 8'h80);
    cpu_read("reen_ff12", 16'hFF12, 8'h00);
    cpu_read("reen_ff24", 16'hFF24, 8'h00);

    // Asynchronous reset kills a pending pulse
    cpu_write(16'hFF14, 8'h80);
    check("pre_rst_restart", ch1_restart, 1'b1);
    nreset = 1'b0;
    #1;
    check("async_rst_restart", ch1_restart, 1'b0);
    check("async_rst_apu_en", apu_en, 1'b0);
    @(negedge clk);
    nreset = 1'b1;
    #1;
    cpu_read("post_rst_ff26", 16'hFF26, 8'h70);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
